mem_ctrl: RTL and testbench

Byte-serial memory controller between the fetch stage's instruction cache and the MEM stage on one side, and the single-port 8-bit RAM/IO bus on the other. It accepts whole-instruction fetches and 1/2/4-byte data loads and stores, arbitrates between them, and sequences them byte by byte over the RAM bus. It reports completion to each requester with a one-cycle ready pulse and exposes a busy level.

---
 rtl/mem_ctrl_pkg.sv | 39 +++
 rtl/mem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: bus widths,
// data_len encodings, the IO address decode and small byte helpers.
package mem_ctrl_pkg;

  localparam int AddrLen = 32;
  localparam int InstLen = 32;

  localparam logic [InstLen-1:0] ZERO_WORD = {InstLen{1'b0}};

  // data_len encodings; 2'b11 is served as a word
  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b10;

  // address bits [17:16] equal to this select the IO space
  localparam logic [1:0] IoSel = 2'b11;

  // Number of bytes moved for a given data_len code.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LenByte: len_bytes = 3'd1;
      LenHalf: len_bytes = 3'd2;
      LenWord: len_bytes = 3'd4;
      default: len_bytes = 3'd4;
    endcase
  endfunction

  // True when the access targets the IO space.
  function automatic logic is_io(input logic [AddrLen-1:0] addr);
    is_io = (addr[17:16] == IoSel);
  endfunction

  // Byte k of a little-endian word.
  function automatic logic [7:0] byte_of(input logic [InstLen-1:0] word,
                                         input logic [1:0] k);
    byte_of = word[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and data
// loads/stores onto the 8-bit RAM/IO bus and sequences them byte by byte.
// Read byte k is addressed at edge t(k) and captured at t(k+2); the step
// counter therefore runs one edge behind the issue side on reads.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_needed,
  input  logic [AddrLen-1:0] inst_addr,
  output logic [InstLen-1:0] inst_data,
  output logic               inst_rdy,
  output logic               inst_busy,
  input  logic               data_needed,
  input  logic               data_wr,
  input  logic [AddrLen-1:0] data_addr,
  input  logic [1:0]         data_len,
  input  logic [InstLen-1:0] data_wdata,
  output logic [InstLen-1:0] data_rdata,
  output logic               data_rdy,
  output logic               data_busy,
  input  logic               io_buffer_full,
  input  logic [7:0]         mem_din,
  output logic [7:0]         mem_dout,
  output logic [AddrLen-1:0] mem_a,
  output logic               mem_wr
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    INST_RD = 2'b01,
    DATA_RD = 2'b10,
    DATA_WR = 2'b11
  } state_t;

  state_t             state;
  logic [2:0]         step;
  logic [2:0]         n;
  logic [AddrLen-1:0] base;
  logic [InstLen-1:0] wbuf;
  logic [InstLen-1:0] rbuf;
  logic               busy;

  logic [2:0]         cap_full;
  logic [1:0]         cap_idx;
  logic [InstLen-1:0] merged;
  logic [AddrLen-1:0] rd_addr;
  logic [AddrLen-1:0] wr_addr;
  logic               wr_stall;
  logic               acc_stall;

  assign inst_busy = busy;
  assign data_busy = busy;

  // Byte being captured this edge, the read word with it merged in, and next bus addresses
  always_comb begin
    cap_full  = step - 3'd1;
    cap_idx   = cap_full[1:0];
    merged    = rbuf;
    merged[{cap_idx, 3'b000} +: 8] = mem_din;
    rd_addr   = base + AddrLen'(step + 3'd1);
    wr_addr   = base + AddrLen'(step);
    wr_stall  = is_io(base) && io_buffer_full;
    acc_stall = is_io(data_addr) && io_buffer_full;
  end

  // Controller FSM: acceptance, byte sequencing, read assembly and completion pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      step       <= 3'd0;
      n          <= 3'd0;
      base       <= {AddrLen{1'b0}};
      wbuf       <= ZERO_WORD;
      rbuf       <= ZERO_WORD;
      busy       <= 1'b0;
      inst_data  <= ZERO_WORD;
      inst_rdy   <= 1'b0;
      data_rdata <= ZERO_WORD;
      data_rdy   <= 1'b0;
      mem_a      <= {AddrLen{1'b0}};
      mem_dout   <= 8'h00;
      mem_wr     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          inst_rdy <= 1'b0;
          data_rdy <= 1'b0;
          mem_wr   <= 1'b0;
          mem_dout <= 8'h00;
          step     <= 3'd0;
          if (data_needed) begin
            // data side wins: the MEM-stage instruction is older
            base   <= data_addr;
            n      <= len_bytes(data_len);
            wbuf   <= data_wdata;
            rbuf   <= ZERO_WORD;
            busy   <= 1'b1;
            mem_a  <= data_addr;
            if (data_wr) begin
              state    <= DATA_WR;
              mem_dout <= data_wdata[7:0];
              if (acc_stall) begin
                mem_wr <= 1'b0;
              end else begin
                mem_wr <= 1'b1;
                step   <= 3'd1;
              end
            end else begin
              state <= DATA_RD;
            end
          end else if (inst_needed) begin
            base  <= inst_addr;
            n     <= 3'd4;
            rbuf  <= ZERO_WORD;
            busy  <= 1'b1;
            mem_a <= inst_addr;
            state <= INST_RD;
          end else begin
            busy <= 1'b0;
          end
        end
        INST_RD, DATA_RD: begin
          if (step == n) begin
            state <= IDLE;
            busy  <= 1'b0;
            step  <= 3'd0;
            if (state == INST_RD) begin
              inst_data <= merged;
              inst_rdy  <= 1'b1;
            end else begin
              data_rdata <= merged;
              data_rdy   <= 1'b1;
            end
          end else begin
            if ((step + 3'd1) < n) begin
              mem_a <= rd_addr;
            end
            if (step != 3'd0) begin
              rbuf <= merged;
            end
            step <= step + 3'd1;
          end
        end
        DATA_WR: begin
          if (step == n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            step     <= 3'd0;
            mem_wr   <= 1'b0;
            mem_dout <= 8'h00;
            data_rdy <= 1'b1;
          end else begin
            mem_a    <= wr_addr;
            mem_dout <= byte_of(wbuf, step[1:0]);
            if (wr_stall) begin
              // UART full: hold this byte and retry next edge
              mem_wr <= 1'b0;
            end else begin
              mem_wr <= 1'b1;
              step   <= step + 3'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          step  <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected completions and bus
// writes into queues; a negedge monitor pops and compares them.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_needed;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_rdy;
  logic        inst_busy;
  logic        data_needed;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [1:0]  data_len;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_rdy;
  logic        data_busy;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .inst_needed(inst_needed), .inst_addr(inst_addr), .inst_data(inst_data),
    .inst_rdy(inst_rdy), .inst_busy(inst_busy),
    .data_needed(data_needed), .data_wr(data_wr), .data_addr(data_addr),
    .data_len(data_len), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_rdy(data_rdy), .data_busy(data_busy),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  typedef struct { logic [31:0] data; int cyc; bit has_data; } exp_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;

  exp_t iq[$];
  exp_t dq[$];
  wr_t  wq[$];
  exp_t mon_e;
  wr_t  mon_w;

  logic [7:0] ref_mem [logic [31:0]];
  logic [7:0] wmem   [0:16383];
  bit         wvalid [0:16383];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // Power-on contents of memory, with the test-plan words in place.
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h13;
      32'h0000_0101: return 8'h05;
      32'h0000_0102: return 8'h00;
      32'h0000_0103: return 8'h00;
      32'h0000_0200: return 8'hEF;
      32'h0000_0201: return 8'hBE;
      32'h0000_0202: return 8'hAD;
      32'h0000_0203: return 8'hDE;
      default:       return 8'h5A ^ a[7:0] ^ {2'b00, a[17:16], a[11:8]};
    endcase
  endfunction

  function automatic logic [13:0] idx(input logic [31:0] a);
    return {a[17:16], a[11:0]};
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return wvalid[idx(a)] ? wmem[idx(a)] : init_byte(a);
  endfunction

  // Reference memory: plain byte-addressed store, updated when a store is issued.
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int nb);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < nb; k++) w[8*k +: 8] = ref_rd(a + 32'(k));
    return w;
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    case (len)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_inst_data"}, 64'(inst_data), 64'd0);
    chk({tag, "_data_rdata"}, 64'(data_rdata), 64'd0);
    chk({tag, "_mem_a"}, 64'(mem_a), 64'd0);
    chk({tag, "_ctrl"}, 64'({mem_dout, inst_rdy, inst_busy, data_rdy, data_busy, mem_wr}), 64'd0);
  endtask

  // RAM model: write on mem_wr, read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_wr) begin
      wmem[idx(mem_a)]   <= mem_dout;
      wvalid[idx(mem_a)] <= 1'b1;
    end
    mem_din <= ram_rd(mem_a);
  end

  // Edge counter used to time completions.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare whenever the DUT presents a completion or a bus write.
  always @(negedge clk) begin
    if (rst) begin
      if (inst_rdy) begin
        if (iq.size() == 0) chk("inst_rdy_unexpected", 64'd1, 64'd0);
        else begin
          mon_e = iq.pop_front();
          chk("inst_data", 64'(inst_data), 64'(mon_e.data));
          chk("inst_rdy_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("busy_at_inst_rdy", 64'({inst_busy, data_busy}), 64'd0);
        end
      end
      if (data_rdy) begin
        if (dq.size() == 0) chk("data_rdy_unexpected", 64'd1, 64'd0);
        else begin
          mon_e = dq.pop_front();
          if (mon_e.has_data) chk("data_rdata", 64'(data_rdata), 64'(mon_e.data));
          chk("data_rdy_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("busy_at_data_rdy", 64'({inst_busy, data_busy}), 64'd0);
        end
      end
      if (mem_wr) begin
        if (wq.size() == 0) chk("mem_wr_unexpected", 64'd1, 64'd0);
        else begin
          mon_w = wq.pop_front();
          chk("wr_addr", 64'(mem_a), 64'(mon_w.addr));
          chk("wr_data", 64'(mem_dout), 64'(mon_w.data));
        end
      end
    end
  end

  task automatic wait_done();
    int left;
    for (int i = 0; i < 60; i++) begin
      if (iq.size() + dq.size() + wq.size() == 0) break;
      @(posedge clk);
    end
    left = iq.size() + dq.size() + wq.size();
    chk("drain_timeout", 64'(left), 64'd0);
    iq.delete();
    dq.delete();
    wq.delete();
  endtask

  // kind: 0 fetch, 1 load, 2 store. s: cycles io_buffer_full is held from acceptance.
  task automatic issue(input int kind, input logic [31:0] addr, input logic [1:0] len,
                       input logic [31:0] wd, input int s);
    int nb;
    int a;
    int st;
    nb = (kind == 0) ? 4 : nbytes(len);
    st = (kind == 2 && addr[17:16] == 2'b11) ? s : 0;
    @(negedge clk);
    a = cyc + 1;
    if (kind == 0) begin
      inst_needed = 1'b1;
      inst_addr   = addr;
      iq.push_back('{ref_word(addr, 4), a + 5, 1'b1});
    end else begin
      data_needed = 1'b1;
      data_wr     = (kind == 2);
      data_addr   = addr;
      data_len    = len;
      data_wdata  = wd;
      if (kind == 1) begin
        dq.push_back('{ref_word(addr, nb), a + nb + 1, 1'b1});
      end else begin
        for (int k = 0; k < nb; k++) begin
          wq.push_back('{addr + 32'(k), wd[8*k +: 8]});
          ref_mem[addr + 32'(k)] = wd[8*k +: 8];
        end
        dq.push_back('{32'h0, a + nb + st, 1'b0});
      end
    end
    io_buffer_full = (s > 0);
    @(posedge clk);
    #1;
    chk("busy_after_accept", 64'({inst_busy, data_busy}), 64'd3);
    @(negedge clk);
    inst_needed = 1'b0;
    data_needed = 1'b0;
    inst_addr   = $urandom;
    data_addr   = $urandom;
    data_wdata  = $urandom;
    data_len    = 2'($urandom_range(0, 3));
    data_wr     = 1'($urandom_range(0, 1));
    if (s > 0) begin
      if (s > 1) repeat (s - 1) @(negedge clk);
      io_buffer_full = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    rst = 1'b0;
    inst_needed = 1'b0; inst_addr = 32'h0;
    data_needed = 1'b0; data_wr = 1'b0; data_addr = 32'h0;
    data_len = 2'b00; data_wdata = 32'h0; io_buffer_full = 1'b0;
    #12;
    check_rst("por");
    @(negedge clk);
    rst = 1'b1;

    // word fetch: expects 0x00000513 at t5
    issue(0, 32'h0000_0100, 2'b10, 32'h0, 0);

    // contention: load word 0x200 first, then the fetch
    @(negedge clk);
    a = cyc + 1;
    data_needed = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0200; data_len = 2'b10;
    inst_needed = 1'b1; inst_addr = 32'h0000_0104;
    dq.push_back('{ref_word(32'h0000_0200, 4), a + 5, 1'b1});
    iq.push_back('{ref_word(32'h0000_0104, 4), a + 11, 1'b1});
    @(posedge clk);
    #1;
    chk("busy_contention", 64'({inst_busy, data_busy}), 64'd3);
    @(negedge clk);
    data_needed = 1'b0;
    repeat (6) @(negedge clk);
    inst_needed = 1'b0;
    wait_done();

    // store half then read back its upper byte
    issue(2, 32'h0000_0302, 2'b01, 32'hABCD_1234, 0);
    issue(1, 32'h0000_0303, 2'b00, 32'h0, 0);

    // IO stall on a store; IO load with full high does not stall
    issue(2, 32'h0003_0000, 2'b00, 32'h0000_0041, 3);
    issue(1, 32'h0003_0000, 2'b00, 32'h0, 2);
    issue(2, 32'h0003_0004, 2'b10, 32'h1122_3344, 2);

    // held request: a second identical load starts after data_rdy
    @(negedge clk);
    a = cyc + 1;
    data_needed = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0303; data_len = 2'b00;
    dq.push_back('{ref_word(32'h0000_0303, 1), a + 2, 1'b1});
    dq.push_back('{ref_word(32'h0000_0303, 1), a + 5, 1'b1});
    @(posedge clk);
    #1;
    chk("busy_held_first", 64'(data_busy), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_held_reaccept", 64'(data_busy), 64'd1);
    @(negedge clk);
    data_needed = 1'b0;
    wait_done();

    // reset in the middle of a fetch: no inst_rdy may follow
    @(negedge clk);
    inst_needed = 1'b1; inst_addr = 32'h0000_0100;
    @(posedge clk);
    @(negedge clk);
    inst_needed = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check_rst("mid_fetch");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    issue(0, 32'h0000_0100, 2'b10, 32'h0, 0);

    // randomized traffic, including IO space and address wrap
    for (int i = 0; i < 40; i++) begin
      int kind;
      int sel;
      int s;
      logic [31:0] ad;
      logic [1:0] ln;
      kind = int'($urandom_range(0, 2));
      sel  = int'($urandom_range(0, 3));
      case (sel)
        0, 1:    ad = 32'h0000_1400 + 32'($urandom_range(0, 63));
        2:       ad = 32'h0003_0000 + 32'($urandom_range(0, 15));
        default: ad = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      endcase
      s  = (sel == 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1));
      ln = 2'($urandom_range(0, 3));
      issue(kind, ad, ln, $urandom, s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
